freq_ramp_ctrl: RTL and testbench
=================================

// Module: freq_ramp_ctrl
// PURPOSE
//  Soft-start/soft-stop setpoint ramp between the HMI frequency setpoint and the VFD PWM core.
//  Takes the operator target frequency and walks the commanded frequency toward it at bounded accel/decel rates.
//  Ramp steps are timed by the 1 ms pulse. Output freq_cmd drives the vfd_top freq input directly.
// PARAMETERS
//  FREQ_W    10    width of all frequency values (0.1 Hz units)
//  FREQ_MAX  500   upper clamp for target and output
//  FREQ_MIN  20    lowest running frequency; nonzero commands below this are raised to it
//  ACC_STEP  5     increment applied per accel tick
//  DEC_STEP  5     decrement applied per decel tick
//  TICK_MS   10    ms pulses per ramp tick (>=1)
// PORTS
//  clk_sys     in   1       system clock
//  rst         in   1       synchronous reset, active-high
//  pluse_ms    in   1       one-clk_sys-cycle strobe every 1 ms
//  run         in   1       1 = drive enabled, 0 = controlled stop
//  estop       in   1       level; 1 = immediate stop, overrides all
//  freq_target in   FREQ_W  operator setpoint, may change any cycle
//  freq_cmd    out  FREQ_W  commanded frequency to PWM core
//  cmd_upd     out  1       1-cycle strobe when freq_cmd changes
//  at_speed    out  1       1 while running and freq_cmd == effective target
//  ramping     out  2       {accel, decel} status, one-hot or 00
// BEHAVIOUR
//  Reset: freq_cmd=0, cmd_upd=0, at_speed=0, ramping=00, state=IDLE, tick counter=0.
//  Effective target tgt = run ? clamp(freq_target) : 0. clamp: >FREQ_MAX -> FREQ_MAX; 1..FREQ_MIN-1 -> FREQ_MIN; 0 -> 0.
//  tgt is registered every cycle (1 cycle latency from freq_target/run to decisions).
//  Tick: counter counts pluse_ms; on count==TICK_MS-1 with pluse_ms, tick=1 for one cycle, counter->0.
//   Counter clears whenever state enters IDLE or HOLD so first step after a new target lands TICK_MS ms later.
//  States:
//   IDLE : freq_cmd=0. tgt!=0 && !estop -> ACCEL.
//   ACCEL: on tick freq_cmd=min(freq_cmd+ACC_STEP, tgt); start from 0 jumps to FREQ_MIN on first tick.
//          freq_cmd==tgt -> HOLD; tgt<freq_cmd -> DECEL (no further accel step that cycle).
//   DECEL: on tick freq_cmd=max(freq_cmd-DEC_STEP, tgt); if result < FREQ_MIN and tgt==0 -> freq_cmd=0.
//          freq_cmd==tgt -> HOLD if tgt!=0 else IDLE; tgt>freq_cmd -> ACCEL.
//   HOLD : freq_cmd unchanged; tgt>freq_cmd -> ACCEL; tgt<freq_cmd -> DECEL.
//  Arithmetic done in FREQ_W+1 bits; no wrap: sum saturates at tgt, difference floors at tgt (never underflows 0).
//  Direction reversal mid-ramp: state changes on the cycle after tgt crosses freq_cmd; freq_cmd never steps
//   past tgt and never moves in the wrong direction.
//  estop=1: next cycle freq_cmd=0, state=IDLE, cmd_upd=1 if freq_cmd was nonzero; held in IDLE while estop=1.
//  estop and tick in same cycle: estop wins. rst and anything: rst wins.
//  cmd_upd asserted in the cycle after freq_cmd register changes value; never asserted for a no-change tick.
//  at_speed = (state==HOLD); ramping = {state==ACCEL, state==DECEL}; all outputs registered.
//  pluse_ms ignored on cycles where rst=1; freq_target changes during reset have no effect.
// STRUCTURE
//  Shared package vfd_pkg: FREQ_W, FREQ_MAX, FREQ_MIN defaults, state encoding localparams
//   (ST_IDLE, ST_ACCEL, ST_DECEL, ST_HOLD), shared with vfd_top and hmi_top.
//  One sub-module: ramp_tick_gen (pluse_ms divider by TICK_MS with sync clear, outputs tick).
//  Top of block: target clamp/register, FSM, saturating step datapath, output regs.
// TESTING
//  1 Reset then run=1, target=100, TICK_MS=1 -> cmd 20,25,...,100 one step per ms; at_speed=1 after 100; cmd_upd per step.
//  2 Hold at 100, target->40 -> decel 95..40 in 5s, stops exactly 40, HOLD; ramping=01 during.
//  3 At 60 accelerating to 300, target->50 at cmd=70 -> DECEL next cycle, 65,60,55,50, never >70.
//  4 run=0 from 100 -> decel to 20, then 0 (15<FREQ_MIN) , IDLE, ramping=00, at_speed=0.
//  5 target=1000 -> clamp, cmd saturates at 500; target=7 -> runs at 20.
//  6 estop=1 mid-accel at 80 -> cmd=0 next cycle, cmd_upd pulse; estop held with run=1 keeps IDLE; release -> ramp from 20.

Source files
------------

// File: rtl/vfd_pkg.sv
// -----------------------------------------------------------------------------
// vfd_pkg
//   Constants and types shared by the VFD blocks (vfd_top, hmi_top and
//   freq_ramp_ctrl).
//   - FREQ_W / FREQ_MAX / FREQ_MIN : default frequency width and limits,
//     all in 0.1 Hz units
//   - ST_* / state_t               : ramp FSM state encoding
//   - ramp_status_t                : {accel, decel} ramp status pair
// -----------------------------------------------------------------------------
package vfd_pkg;

    localparam int FREQ_W   = 10;
    localparam int FREQ_MAX = 500;
    localparam int FREQ_MIN = 20;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCEL = 2'd1;
    localparam state_t ST_DECEL = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

    typedef struct packed {
        logic accel;
        logic decel;
    } ramp_status_t;

endpackage

// File: rtl/ramp_tick_gen.sv
// -----------------------------------------------------------------------------
// ramp_tick_gen
//   Divides the 1 ms strobe by TICK_MS to produce the ramp step tick.
//   Ports:
//     clk    in  system clock
//     rst    in  synchronous reset, active-high (strobes ignored while high)
//     pulse  in  one-cycle 1 ms strobe
//     clr    in  synchronous clear; restarts the ms count from zero
//     tick   out one-cycle ramp step, high with the TICK_MS-th counted strobe
// -----------------------------------------------------------------------------
module ramp_tick_gen #(
    parameter int TICK_MS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_MS > 1) ? $clog2(TICK_MS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_MS - 1);

    logic [CNT_W-1:0] cnt;

    // Combinational so the step lands on the same edge as the strobe that
    // completes the count; a clear in the same cycle suppresses it.
    assign tick = pulse && !rst && !clr && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (pulse) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/freq_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// freq_ramp_ctrl
//   Soft-start / soft-stop ramp between the HMI setpoint and the PWM core.
//   Walks freq_cmd toward the clamped operator target at ACC_STEP / DEC_STEP
//   per ramp tick (TICK_MS ms per tick). estop forces an immediate stop.
//   Ports:
//     clk_sys      in  system clock
//     rst          in  synchronous reset, active-high
//     pluse_ms     in  one-cycle strobe every 1 ms
//     run          in  1 = drive enabled, 0 = controlled stop
//     estop        in  level, immediate stop, overrides everything
//     freq_target  in  operator setpoint (0.1 Hz)
//     freq_cmd     out commanded frequency to the PWM core
//     cmd_upd      out one-cycle strobe, high while a new freq_cmd is first shown
//     at_speed     out high in HOLD (freq_cmd equals the nonzero target)
//     ramping      out {accel, decel} status
// -----------------------------------------------------------------------------
module freq_ramp_ctrl #(
    parameter int FREQ_W   = vfd_pkg::FREQ_W,
    parameter int FREQ_MAX = vfd_pkg::FREQ_MAX,
    parameter int FREQ_MIN = vfd_pkg::FREQ_MIN,
    parameter int ACC_STEP = 5,
    parameter int DEC_STEP = 5,
    parameter int TICK_MS  = 10
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              pluse_ms,
    input  logic              run,
    input  logic              estop,
    input  logic [FREQ_W-1:0] freq_target,
    output logic [FREQ_W-1:0] freq_cmd,
    output logic              cmd_upd,
    output logic              at_speed,
    output logic [1:0]        ramping
);

    import vfd_pkg::*;

    // One extra bit so the up-step sum cannot wrap before saturation.
    localparam int EW = FREQ_W + 1;
    localparam logic [EW-1:0] MAX_E = EW'(FREQ_MAX);
    localparam logic [EW-1:0] MIN_E = EW'(FREQ_MIN);
    localparam logic [EW-1:0] ACC_E = EW'(ACC_STEP);
    localparam logic [EW-1:0] DEC_E = EW'(DEC_STEP);

    function automatic logic [FREQ_W-1:0] clamp_tgt(input logic [FREQ_W-1:0] f);
        logic [EW-1:0] fe;
        fe = {1'b0, f};
        if (fe > MAX_E) begin
            return MAX_E[FREQ_W-1:0];
        end else if (f != '0 && fe < MIN_E) begin
            return MIN_E[FREQ_W-1:0];
        end
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Registered effective target (0 when stopped)
    // ------------------------------------------------------------------
    logic [FREQ_W-1:0] tgt;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            tgt <= '0;
        end else begin
            tgt <= run ? clamp_tgt(freq_target) : '0;
        end
    end

    // ------------------------------------------------------------------
    // Ramp tick; the ms count is held clear while idle or holding so the
    // first step of a new ramp lands a full TICK_MS after it starts.
    // ------------------------------------------------------------------
    state_t state, state_nxt;
    logic   tick, tick_clr;

    assign tick_clr = (state_nxt == ST_IDLE) || (state_nxt == ST_HOLD);

    ramp_tick_gen #(
        .TICK_MS (TICK_MS)
    ) u_tick (
        .clk   (clk_sys),
        .rst   (rst),
        .pulse (pluse_ms),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // ------------------------------------------------------------------
    // Saturating step datapath
    // ------------------------------------------------------------------
    logic [EW-1:0] cmd_e, tgt_e, up_e, up_sat, diff_e, dn_e;

    always_comb begin
        cmd_e  = {1'b0, freq_cmd};
        tgt_e  = {1'b0, tgt};
        // From standstill the first step goes straight to the running minimum.
        up_e   = (freq_cmd == '0) ? MIN_E : cmd_e + ACC_E;
        up_sat = (up_e > tgt_e) ? tgt_e : up_e;
        // diff_e only matters while cmd > tgt, so the wrap for cmd < tgt is harmless.
        // Comparing the gap instead of subtracting keeps the floor at tgt.
        diff_e = cmd_e - tgt_e;
        dn_e   = (diff_e > DEC_E) ? cmd_e - DEC_E : tgt_e;
        // Ramping down to stop: below the running minimum just go to zero.
        if (tgt == '0 && dn_e < MIN_E) begin
            dn_e = '0;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (estop) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (tgt != '0) state_nxt = ST_ACCEL;
                end
                ST_ACCEL: begin
                    if (tgt < freq_cmd)       state_nxt = ST_DECEL;
                    else if (tgt == freq_cmd) state_nxt = (tgt != '0) ? ST_HOLD : ST_IDLE;
                end
                ST_DECEL: begin
                    if (tgt > freq_cmd)       state_nxt = ST_ACCEL;
                    else if (tgt == freq_cmd) state_nxt = (tgt != '0) ? ST_HOLD : ST_IDLE;
                end
                ST_HOLD: begin
                    if (tgt > freq_cmd)      state_nxt = ST_ACCEL;
                    else if (tgt < freq_cmd) state_nxt = ST_DECEL;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath next values. A step is only taken when the FSM
    // stays in its ramp state, so a reversal never moves one more step the
    // wrong way.
    // ------------------------------------------------------------------
    logic [FREQ_W-1:0] cmd_nxt;
    logic              upd_nxt, at_speed_nxt;
    ramp_status_t      ramp_nxt;

    always_comb begin
        cmd_nxt = freq_cmd;
        if (estop) begin
            cmd_nxt = '0;
        end else if (tick) begin
            if (state == ST_ACCEL && state_nxt == ST_ACCEL) begin
                cmd_nxt = up_sat[FREQ_W-1:0];
            end else if (state == ST_DECEL && state_nxt == ST_DECEL) begin
                cmd_nxt = dn_e[FREQ_W-1:0];
            end
        end
        upd_nxt        = (cmd_nxt != freq_cmd);
        at_speed_nxt   = (state_nxt == ST_HOLD);
        ramp_nxt.accel = (state_nxt == ST_ACCEL);
        ramp_nxt.decel = (state_nxt == ST_DECEL);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state    <= ST_IDLE;
            freq_cmd <= '0;
            cmd_upd  <= 1'b0;
            at_speed <= 1'b0;
            ramping  <= 2'b00;
        end else begin
            state    <= state_nxt;
            freq_cmd <= cmd_nxt;
            cmd_upd  <= upd_nxt;
            at_speed <= at_speed_nxt;
            ramping  <= ramp_nxt;
        end
    end

endmodule

// File: tb/tb_freq_ramp_ctrl.sv
// Two instances share all inputs: one with a 1 ms ramp tick, one with 3 ms.
module tb_freq_ramp_ctrl;

    localparam int FW   = 10;
    localparam int FMAX = 500;
    localparam int FMIN = 20;
    localparam int ACC  = 5;
    localparam int DEC  = 5;

    logic clk = 1'b0;
    logic rst, pluse_ms, run, estop;
    logic [FW-1:0] freq_target;
    logic [FW-1:0] cmd0, cmd1;
    logic upd0, upd1, as0, as1;
    logic [1:0] rmp0, rmp1;

    always #5 clk = ~clk;

    freq_ramp_ctrl #(.FREQ_W(FW), .FREQ_MAX(FMAX), .FREQ_MIN(FMIN),
                     .ACC_STEP(ACC), .DEC_STEP(DEC), .TICK_MS(1)) dut (
        .clk_sys(clk), .rst(rst), .pluse_ms(pluse_ms), .run(run), .estop(estop),
        .freq_target(freq_target), .freq_cmd(cmd0), .cmd_upd(upd0),
        .at_speed(as0), .ramping(rmp0));

    freq_ramp_ctrl #(.FREQ_W(FW), .FREQ_MAX(FMAX), .FREQ_MIN(FMIN),
                     .ACC_STEP(ACC), .DEC_STEP(DEC), .TICK_MS(3)) dut3 (
        .clk_sys(clk), .rst(rst), .pluse_ms(pluse_ms), .run(run), .estop(estop),
        .freq_target(freq_target), .freq_cmd(cmd1), .cmd_upd(upd1),
        .at_speed(as1), .ramping(rmp1));

    int total = 0;
    int bad   = 0;
    int ms_per = 4;
    int ph = 0;
    int log0[$];

    // ---------------- reference model ----------------
    // The ramp direction is the sign of (target - command); the command moves
    // one step on a tick only when the direction already chosen last cycle
    // still holds.
    int m_cmd[2] = '{0, 0};
    int m_dir[2] = '{0, 0};
    int m_cnt[2] = '{0, 0};
    bit m_hold[2] = '{0, 0};
    bit m_upd[2] = '{0, 0};
    int m_tgt = 0;
    int t_nc, t_nd, d_now;
    bit t_tick;

    function automatic int tms(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int clampf(input int t);
        if (t > FMAX) return FMAX;
        if (t > 0 && t < FMIN) return FMIN;
        return t;
    endfunction

    function automatic int sgn(input int x);
        return (x > 0) ? 1 : (x < 0) ? -1 : 0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_cmd[k] = 0; m_dir[k] = 0; m_cnt[k] = 0; m_hold[k] = 0; m_upd[k] = 0;
            end else begin
                t_tick = pluse_ms && (m_cnt[k] == tms(k) - 1);
                d_now  = sgn(m_tgt - m_cmd[k]);
                t_nc   = m_cmd[k];
                t_nd   = d_now;
                if (estop) begin
                    t_nc = 0;
                    t_nd = 0;
                end else if (t_tick && m_dir[k] != 0 && m_dir[k] == d_now) begin
                    if (d_now > 0) begin
                        t_nc = (m_cmd[k] == 0) ? FMIN
                             : ((m_cmd[k] + ACC > m_tgt) ? m_tgt : m_cmd[k] + ACC);
                    end else begin
                        t_nc = (m_cmd[k] - DEC < m_tgt) ? m_tgt : m_cmd[k] - DEC;
                        if (t_nc < FMIN && m_tgt == 0) t_nc = 0;
                    end
                end
                m_hold[k] = !estop && t_nd == 0 && m_tgt != 0;
                m_cnt[k]  = (t_nd == 0) ? 0 : (pluse_ms ? (m_cnt[k] + 1) % tms(k) : m_cnt[k]);
                m_upd[k]  = (t_nc != m_cmd[k]);
                m_cmd[k]  = t_nc;
                m_dir[k]  = t_nd;
            end
        end
        m_tgt = rst ? 0 : (run ? clampf(int'(freq_target)) : 0);
    end

    logic [27:0] obs;
    assign obs = {cmd0, upd0, as0, rmp0, cmd1, upd1, as1, rmp1};

    function automatic logic [27:0] expv();
        logic [13:0] e0, e1;
        e0 = {10'(m_cmd[0]), m_upd[0], m_hold[0], m_dir[0] > 0, m_dir[0] < 0};
        e1 = {10'(m_cmd[1]), m_upd[1], m_hold[1], m_dir[1] > 0, m_dir[1] < 0};
        return {e0, e1};
    endfunction

    // index of first difference, -1 when the sequences match
    function automatic int first_diff(input int a[$], input int b[$]);
        for (int i = 0; i < a.size() && i < b.size(); i++)
            if (a[i] != b[i]) return i;
        if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
        return -1;
    endfunction

    function automatic int q_at(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1;
    endfunction

    // advance one clock with the 1 ms strobe pattern; no checking here
    task automatic cyc();
        pluse_ms = (ph == 0);
        ph = (ph + 1 >= ms_per) ? 0 : ph + 1;
        @(posedge clk);
        #1;
        if (upd0) log0.push_back(int'(cmd0));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; run = 1'b1; estop = 1'b0; freq_target = 10'd100;
        repeat (6) begin
            cyc();
            freq_target = 10'($urandom_range(1, 1023));
            total++;
            if (obs !== 28'h0) begin
                bad++; $display("FAIL reset_state got=%h want=0", obs);
            end
        end
        run = 1'b0;
        rst = 1'b0;
        repeat (3) begin
            cyc(); total++;
            if (obs !== expv() || cmd0 !== 10'd0) begin
                bad++; $display("FAIL reset_idle got=%h want=%h", obs, expv());
            end
        end
    endtask

    task automatic test_accel();
        int exp_q[$];
        log0.delete();
        run = 1'b1; freq_target = 10'd100;
        for (int i = 0; i < 1000 && !(as0 && as1); i++) begin
            cyc(); total++;
            if (obs !== expv()) begin bad++; $display("FAIL accel_model got=%h want=%h", obs, expv()); end
        end
        for (int v = 20; v <= 100; v += 5) exp_q.push_back(v);
        total++;
        if (first_diff(log0, exp_q) != -1) begin
            bad++; $display("FAIL accel_seq idx=%0d got=%0d want=%0d", first_diff(log0, exp_q),
                            q_at(log0, first_diff(log0, exp_q)), q_at(exp_q, first_diff(log0, exp_q)));
        end
        total++;
        if (!(as0 && as1) || cmd0 !== 10'd100 || cmd1 !== 10'd100 || rmp0 !== 2'b00) begin
            bad++; $display("FAIL accel_final cmd0=%0d cmd1=%0d as=%b%b want 100/100/11", cmd0, cmd1, as0, as1);
        end
    endtask

    task automatic test_decel();
        int exp_q[$];
        log0.delete();
        freq_target = 10'd40;
        repeat (3) begin
            cyc(); total++;
            if (obs !== expv()) begin bad++; $display("FAIL decel_model got=%h want=%h", obs, expv()); end
        end
        for (int i = 0; i < 1000 && !(as0 && as1); i++) begin
            cyc(); total++;
            if (obs !== expv()) begin bad++; $display("FAIL decel_model got=%h want=%h", obs, expv()); end
            if (!as0) begin
                total++;
                if (rmp0 !== 2'b01) begin bad++; $display("FAIL decel_ramping got=%b want=01", rmp0); end
            end
        end
        for (int v = 95; v >= 40; v -= 5) exp_q.push_back(v);
        total++;
        if (first_diff(log0, exp_q) != -1) begin
            bad++; $display("FAIL decel_seq idx=%0d got=%0d want=%0d", first_diff(log0, exp_q),
                            q_at(log0, first_diff(log0, exp_q)), q_at(exp_q, first_diff(log0, exp_q)));
        end
        total++;
        if (cmd0 !== 10'd40 || cmd1 !== 10'd40 || !(as0 && as1)) begin
            bad++; $display("FAIL decel_final cmd0=%0d cmd1=%0d want 40 hold", cmd0, cmd1);
        end
    endtask

    task automatic test_reverse();
        int exp_q[$];
        int peak;
        bit hit;
        freq_target = 10'd300;
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            cyc(); total++;
            if (obs !== expv()) begin bad++; $display("FAIL rev_model got=%h want=%h", obs, expv()); end
            hit = upd0 && cmd0 == 10'd70;
        end
        total++;
        if (!hit) begin bad++; $display("FAIL rev_reach70 got=%0d want=70", cmd0); end
        log0.delete();
        freq_target = 10'd50;
        peak = int'(cmd0);
        repeat (2) begin
            cyc(); total++;
            if (obs !== expv()) begin bad++; $display("FAIL rev_model got=%h want=%h", obs, expv()); end
        end
        total++;
        if (rmp0 !== 2'b01) begin bad++; $display("FAIL rev_turn ramping=%b want=01", rmp0); end
        for (int i = 0; i < 1000 && !(as0 && as1); i++) begin
            cyc(); total++;
            if (obs !== expv()) begin bad++; $display("FAIL rev_model got=%h want=%h", obs, expv()); end
            if (int'(cmd0) > peak) peak = int'(cmd0);
        end
        exp_q = '{65, 60, 55, 50};
        total++;
        if (first_diff(log0, exp_q) != -1 || peak > 70) begin
            bad++; $display("FAIL rev_seq idx=%0d got=%0d want=%0d peak=%0d max=70", first_diff(log0, exp_q),
                            q_at(log0, first_diff(log0, exp_q)), q_at(exp_q, first_diff(log0, exp_q)), peak);
        end
    endtask

    task automatic test_stop();
        int exp_q[$];
        freq_target = 10'd100;
        repeat (3) cyc();
        for (int i = 0; i < 1000 && !(as0 && as1); i++) begin
            cyc(); total++;
            if (obs !== expv()) begin bad++; $display("FAIL stop_model got=%h want=%h", obs, expv()); end
        end
        log0.delete();
        run = 1'b0;
        repeat (3) cyc();
        for (int i = 0; i < 1000 && !(cmd0 == 0 && cmd1 == 0 && rmp0 == 0 && rmp1 == 0); i++) begin
            cyc(); total++;
            if (obs !== expv()) begin bad++; $display("FAIL stop_model got=%h want=%h", obs, expv()); end
        end
        for (int v = 95; v >= 20; v -= 5) exp_q.push_back(v);
        exp_q.push_back(0);
        total++;
        if (first_diff(log0, exp_q) != -1) begin
            bad++; $display("FAIL stop_seq idx=%0d got=%0d want=%0d", first_diff(log0, exp_q),
                            q_at(log0, first_diff(log0, exp_q)), q_at(exp_q, first_diff(log0, exp_q)));
        end
        cyc();
        total++;
        if (cmd0 !== 10'd0 || as0 !== 1'b0 || rmp0 !== 2'b00 || cmd1 !== 10'd0 || as1 !== 1'b0) begin
            bad++; $display("FAIL stop_idle cmd0=%0d as0=%b rmp0=%b want 0/0/00", cmd0, as0, rmp0);
        end
        run = 1'b1;
    endtask

    task automatic test_clamp();
        freq_target = 10'd1000;
        repeat (3) cyc();
        for (int i = 0; i < 3000 && !(as0 && as1); i++) begin
            cyc(); total++;
            if (obs !== expv()) begin bad++; $display("FAIL clamp_model got=%h want=%h", obs, expv()); end
        end
        total++;
        if (cmd0 !== 10'd500 || cmd1 !== 10'd500) begin
            bad++; $display("FAIL clamp_max cmd0=%0d cmd1=%0d want 500", cmd0, cmd1);
        end
        freq_target = 10'd7;
        repeat (3) cyc();
        for (int i = 0; i < 3000 && !(as0 && as1); i++) begin
            cyc(); total++;
            if (obs !== expv()) begin bad++; $display("FAIL clamp_model got=%h want=%h", obs, expv()); end
        end
        total++;
        if (cmd0 !== 10'd20 || cmd1 !== 10'd20 || !(as0 && as1)) begin
            bad++; $display("FAIL clamp_min cmd0=%0d cmd1=%0d want 20", cmd0, cmd1);
        end
    endtask

    task automatic test_estop();
        bit hit;
        freq_target = 10'd300;
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            cyc(); total++;
            if (obs !== expv()) begin bad++; $display("FAIL estop_model got=%h want=%h", obs, expv()); end
            hit = (cmd0 == 10'd80);
        end
        estop = 1'b1;
        cyc();
        total++;
        if (!hit || cmd0 !== 10'd0 || upd0 !== 1'b1 || obs !== expv()) begin
            bad++; $display("FAIL estop_stop cmd0=%0d upd0=%b want 0/1 (reach=%b)", cmd0, upd0, hit);
        end
        repeat (20) begin
            cyc(); total++;
            if (obs !== expv() || cmd0 !== 10'd0 || rmp0 !== 2'b00 || upd0 !== 1'b0) begin
                bad++; $display("FAIL estop_hold got=%h want=%h", obs, expv());
            end
        end
        estop = 1'b0;
        log0.delete();
        for (int i = 0; i < 300 && log0.size() == 0; i++) begin
            cyc(); total++;
            if (obs !== expv()) begin bad++; $display("FAIL estop_model got=%h want=%h", obs, expv()); end
        end
        total++;
        if (q_at(log0, 0) != 20) begin
            bad++; $display("FAIL estop_restart got=%0d want=20", q_at(log0, 0));
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 25) freq_target = (r < 8) ? 10'($urandom_range(0, 30)) : 10'($urandom);
            else if (r < 35) run = ~run;
            else if (r < 40) estop = ~estop;
            else if (r < 42) rst = 1'b1;
            else if (r < 47) ms_per = int'($urandom_range(1, 6));
            else rst = 1'b0;
            if (estop && r > 900) estop = 1'b0;
            cyc(); total++;
            if (obs !== expv()) begin bad++; $display("FAIL random_model cyc=%0d got=%h want=%h", i, obs, expv()); end
        end
    endtask

    initial begin
        rst = 1'b1; pluse_ms = 1'b0; run = 1'b0; estop = 1'b0; freq_target = '0;
        test_reset();
        test_accel();
        test_decel();
        test_reverse();
        test_stop();
        test_clamp();
        test_estop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
